servclone10_pll_reset_ctrl: RTL and testbench

SERVCLONE10_PLL_RESET_CTRL -- requirements
Module: servclone10_pll_reset_ctrl

---
 rtl/servclone10_pll_reset_ctrl.sv | 157 +++++++++++++++
 tb/tb_servclone10_pll_reset_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/servclone10_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// servclone10_pll_reset_ctrl
//
// Purpose:
//   Brings a PLL out of reset and supervises its lock. Each acquisition attempt
//   holds the PLL in reset, waits a bounded time for lock, then requires the
//   lock to stay up for a number of consecutive cycles before declaring the
//   clock ready. Failed attempts are retried a limited number of times, after
//   which the block parks in a sticky failure state until reset. Loss of lock
//   while running restarts acquisition with a fresh retry budget.
//
// Ports:
//   i_clk        - raw board oscillator clock (only clock)
//   i_rst        - synchronous, active-high reset
//   i_locked     - PLL lock indicator, asynchronous to i_clk
//   o_pll_areset - PLL reset, active-high (high in HOLD and FAIL)
//   o_ready      - PLL locked and stable (high only in RUN)
//   o_fail       - sticky acquisition failure (high only in FAIL)
//   o_lock_lost  - one-cycle pulse on the first HOLD cycle after losing lock
//   o_retries    - retry count of the current acquisition attempt
// -----------------------------------------------------------------------------
module servclone10_pll_reset_ctrl #(
  parameter int HOLD_CYCLES   = 12,
  parameter int LOCK_TIMEOUT  = 12000,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_locked,
  output logic       o_pll_areset,
  output logic       o_ready,
  output logic       o_fail,
  output logic       o_lock_lost,
  output logic [2:0] o_retries
);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [2:0]  RETRY_MAX    = 3'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  retries_q, retries_d;
  logic        locked_meta_q, locked_s_q;
  logic        areset_q, areset_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;
  logic        lock_lost_q, lock_lost_d;

  // State register, counter, retry count, lock synchronizer and the
  // registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      state_q       <= S_HOLD;
      cnt_q         <= 16'd0;
      retries_q     <= 3'd0;
      areset_q      <= 1'b1;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      locked_meta_q <= i_locked;
      locked_s_q    <= locked_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retries_q     <= retries_d;
      areset_q      <= areset_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  // Next-state logic. Every transition clears the counter; RUN and FAIL
  // freeze it since nothing there is timed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    retries_d = retries_q;
    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_WAIT;
          cnt_d   = 16'd0;
        end
      end
      S_WAIT: begin
        // Lock is checked first so a lock on the timeout cycle still wins.
        if (locked_s_q) begin
          state_d = S_STABLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = 16'd0;
          if (retries_q == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            // Only reached below RETRY_MAX, so the count saturates there.
            state_d   = S_HOLD;
            retries_d = retries_q + 3'd1;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s_q) begin
          state_d = S_WAIT;
          cnt_d   = 16'd0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = 16'd0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!locked_s_q) begin
          state_d   = S_HOLD;
          cnt_d     = 16'd0;
          retries_d = 3'd0;
        end
      end
      S_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // line up exactly with the cycles spent in each state.
  always_comb begin
    areset_d    = (state_d == S_HOLD) || (state_d == S_FAIL);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
    lock_lost_d = (state_q == S_RUN) && (state_d == S_HOLD);
  end

  assign o_pll_areset = areset_q;
  assign o_ready      = ready_q;
  assign o_fail       = fail_q;
  assign o_lock_lost  = lock_lost_q;
  assign o_retries    = retries_q;

endmodule

// File: tb/tb_servclone10_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_servclone10_pll_reset_ctrl
//
// Drives directed and randomized reset/lock sequences into the PLL reset
// controller. A reference model, expressed as phases with absolute-cycle
// deadlines, predicts the outputs after every clock edge and queues them; a
// monitor pops one expectation per edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_servclone10_pll_reset_ctrl;

  localparam int H  = 4;
  localparam int T  = 20;
  localparam int S  = 8;
  localparam int MR = 2;

  localparam int PH_HOLD = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RUN  = 3;
  localparam int PH_FAIL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       o_pll_areset;
  logic       o_ready;
  logic       o_fail;
  logic       o_lock_lost;
  logic [2:0] o_retries;

  servclone10_pll_reset_ctrl #(
    .HOLD_CYCLES  (H),
    .LOCK_TIMEOUT (T),
    .STABLE_CYCLES(S),
    .MAX_RETRIES  (MR)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_locked    (locked),
    .o_pll_areset(o_pll_areset),
    .o_ready     (o_ready),
    .o_fail      (o_fail),
    .o_lock_lost (o_lock_lost),
    .o_retries   (o_retries)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       areset;
    logic       ready;
    logic       fail;
    logic       lost;
    logic [2:0] retries;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: current phase, the edge number at which the phase's
  // time budget expires, attempts used, and the two-sample lock delay line.
  int cyc      = 0;
  int phase    = PH_HOLD;
  int deadline = H;
  int tries    = 0;
  bit sync1    = 1'b0;
  bit sync2    = 1'b0;
  bit lost_m   = 1'b0;

  // Advance the model across one clock edge that samples (r, l).
  function automatic void model_edge(input logic r, input logic l);
    bit ls;
    ls     = sync2;
    lost_m = 1'b0;
    if (r) begin
      sync1    = 1'b0;
      sync2    = 1'b0;
      phase    = PH_HOLD;
      deadline = cyc + H;
      tries    = 0;
      return;
    end
    sync2 = sync1;
    sync1 = l;
    case (phase)
      PH_HOLD: if (cyc == deadline) begin
        phase    = PH_WAIT;
        deadline = cyc + T;
      end
      PH_WAIT: begin
        if (ls) begin
          phase    = PH_STAB;
          deadline = cyc + S;
        end else if (cyc == deadline) begin
          if (tries == MR) phase = PH_FAIL;
          else begin
            tries    = tries + 1;
            phase    = PH_HOLD;
            deadline = cyc + H;
          end
        end
      end
      PH_STAB: begin
        if (!ls) begin
          phase    = PH_WAIT;
          deadline = cyc + T;
        end else if (cyc == deadline) begin
          phase = PH_RUN;
        end
      end
      PH_RUN: if (!ls) begin
        phase    = PH_HOLD;
        deadline = cyc + H;
        tries    = 0;
        lost_m   = 1'b1;
      end
      default: ;
    endcase
  endfunction

  // Apply inputs for the next edge, queue the model's prediction, and move to
  // the following falling edge.
  task automatic step(input logic r, input logic l);
    exp_t e;
    rst    = r;
    locked = l;
    cyc    = cyc + 1;
    model_edge(r, l);
    e.areset  = (phase == PH_HOLD) || (phase == PH_FAIL);
    e.ready   = (phase == PH_RUN);
    e.fail    = (phase == PH_FAIL);
    e.lost    = lost_m;
    e.retries = 3'(tries);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one expectation per rising edge, sampled just after it.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {o_pll_areset, o_ready, o_fail, o_lock_lost, o_retries};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got areset=%b ready=%b fail=%b lost=%b retries=%0d, expected areset=%b ready=%b fail=%b lost=%b retries=%0d",
                   $time, got.areset, got.ready, got.fail, got.lost, got.retries,
                   e.areset, e.ready, e.fail, e.lost, e.retries);
        end
      end
    end
  end

  initial begin
    int lvl;
    int len;
    rst    = 1'b1;
    locked = 1'b0;

    // Reset state, then nominal acquisition: lock 3 cycles after areset falls.
    repeat (3) step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b1);
    // Loss of lock while running, then reacquire.
    repeat (10) step(1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1);

    // Glitch during STABLE.
    repeat (2) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b1);

    // Persistent no-lock: retries, terminal FAIL, then reset out of FAIL.
    repeat (2) step(1'b1, 1'b0);
    repeat (100) step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b0);

    // Lock arriving around the exact timeout cycle of the first attempt.
    for (int d = 19; d <= 24; d++) begin
      repeat (2) step(1'b1, 1'b0);
      repeat (d) step(1'b0, 1'b0);
      repeat (15) step(1'b0, 1'b1);
    end

    // Reset asserted while running.
    repeat (2) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    repeat (15) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);

    // Randomized lock segments with occasional resets.
    for (int seg = 0; seg < 250; seg++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++)
        step(($urandom_range(0, 299) == 0), lvl[0]);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
